// File: rtl/image_window_renderer.sv
`default_nettype none
// ============================================================================
// Module   : image_window_renderer
// Desc     : Maps the VGA scan position onto a movable, scalable image window,
//            issues the frame-memory read for window pixels and realigns the
//            returned word with the delayed display enable and syncs.
// Revision : 1.0 - initial release
// ============================================================================
module image_window_renderer #(
  parameter int          IMG_W       = 200,
  parameter int          IMG_H       = 200,
  parameter int          SCALE_LOG2  = 0,
  parameter int          FORMAT      = 0,
  parameter int          MEM_LATENCY = 1,
  parameter int          ADDR_W      = 16,
  parameter logic [9:0]  ORG_X_DEF   = 10'd0,
  parameter logic [9:0]  ORG_Y_DEF   = 10'd0,
  parameter logic [23:0] BG_COLOR    = 24'h555555
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              de_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic [9:0]        org_x_in,
  input  logic [9:0]        org_y_in,
  input  logic              org_load,
  input  logic [31:0]       ReadData,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o
);

  // Window extent in screen pixels; kept wide so origin + extent never wraps
  localparam int WIN_W = IMG_W << SCALE_LOG2;
  localparam int WIN_H = IMG_H << SCALE_LOG2;

  // Side-band information that travels with each read through the pipeline
  typedef struct packed {
    logic       in_win;
    logic       de;
    logic       hs;
    logic       vs;
    logic [1:0] bsel;
  } tag_t;

  logic [9:0]  shadow_x;
  logic [9:0]  shadow_y;
  logic [9:0]  org_x;
  logic [9:0]  org_y;

  logic [15:0] x_end;
  logic [15:0] y_end;
  logic        in_win;
  logic [9:0]  rx;
  logic [9:0]  ry;
  logic [31:0] idx;
  logic [31:0] word;
  logic [1:0]  byte_sel;

  tag_t        tag_s0;
  tag_t        tag_pipe [MEM_LATENCY];
  tag_t        tag_out;

  logic [31:0] shifted;
  logic [7:0]  pix8;
  logic [23:0] win_rgb;
  logic [23:0] rgb_next;
  logic        unused_bits;

  // Shadow origin captures org_load; active origin only follows it during
  // vsync so a pending move never tears the current frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_x <= ORG_X_DEF;
      shadow_y <= ORG_Y_DEF;
      org_x    <= ORG_X_DEF;
      org_y    <= ORG_Y_DEF;
    end else begin
      if (org_load) begin
        shadow_x <= org_x_in;
        shadow_y <= org_y_in;
      end
      if (vsync_i) begin
        org_x <= shadow_x;
        org_y <= shadow_y;
      end
    end
  end

  // Window test and source-pixel index for the current scan position
  always_comb begin
    x_end    = {6'd0, org_x} + 16'(WIN_W);
    y_end    = {6'd0, org_y} + 16'(WIN_H);
    in_win   = de_i
               && (x >= org_x) && ({6'd0, x} < x_end)
               && (y >= org_y) && ({6'd0, y} < y_end);
    rx       = (x - org_x) >> SCALE_LOG2;
    ry       = (y - org_y) >> SCALE_LOG2;
    idx      = 32'(ry) * 32'(IMG_W) + 32'(rx);
    word     = (FORMAT == 1) ? (idx >> 2) : idx;
    byte_sel = idx[1:0];
  end

  // Stage 0: issue the read for window pixels and tag it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      tag_s0    <= '0;
    end else begin
      mem_rd_en <= in_win;
      if (in_win) begin
        mem_addr <= word[ADDR_W-1:0];
      end
      tag_s0.in_win <= in_win;
      tag_s0.de     <= de_i;
      tag_s0.hs     <= hsync_i;
      tag_s0.vs     <= vsync_i;
      tag_s0.bsel   <= byte_sel;
    end
  end

  // Tag delay line matching the memory read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_s0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_out = tag_pipe[MEM_LATENCY-1];

  // Colour selection: blanking, background or unpacked memory pixel
  always_comb begin
    shifted = ReadData >> {tag_out.bsel, 3'b000};
    pix8    = shifted[7:0];
    if (FORMAT == 1) begin
      win_rgb = {pix8[7:5], pix8[7:5], pix8[7:6],
                 pix8[4:2], pix8[4:2], pix8[4:3],
                 pix8[1:0], pix8[1:0], pix8[1:0], pix8[1:0]};
    end else begin
      win_rgb = ReadData[23:0];
    end
    if (!tag_out.de) begin
      rgb_next = 24'h000000;
    end else if (!tag_out.in_win) begin
      rgb_next = BG_COLOR;
    end else begin
      rgb_next = win_rgb;
    end
  end

  // Output stage: register colour and the realigned enable/syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red     <= 8'd0;
      green   <= 8'd0;
      blue    <= 8'd0;
      de_o    <= 1'b0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      red     <= rgb_next[23:16];
      green   <= rgb_next[15:8];
      blue    <= rgb_next[7:0];
      de_o    <= tag_out.de;
      hsync_o <= tag_out.hs;
      vsync_o <= tag_out.vs;
    end
  end

  // Upper word bits beyond the address width are intentionally dropped
  assign unused_bits = ^{shifted[31:8], word};

endmodule
`default_nettype wire

// File: tb/tb_image_window_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_window_renderer
// Desc     : Two renderer instances (RGB888 unscaled, RGB332 2x scaled with
//            deeper memory latency) driven by shared scan stimulus and checked
//            every cycle against a behavioural window/origin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_window_renderer;

  localparam int HN = 16;
  localparam logic [23:0] BG = 24'h555555;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  x, y, org_x_in, org_y_in;
  logic        de_i, hsync_i, vsync_i, org_load;
  logic [31:0] rd_a, rd_b;
  logic [15:0] addr_a, addr_b;
  logic        en_a, en_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        de_a, hs_a, vs_a, de_b, hs_b, vs_b;

  int checks;
  int errors;

  image_window_renderer #(
    .IMG_W(200), .IMG_H(200), .SCALE_LOG2(0), .FORMAT(0), .MEM_LATENCY(1),
    .ADDR_W(16), .ORG_X_DEF(10'd0), .ORG_Y_DEF(10'd0), .BG_COLOR(BG)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de_i(de_i), .hsync_i(hsync_i),
    .vsync_i(vsync_i), .org_x_in(org_x_in), .org_y_in(org_y_in),
    .org_load(org_load), .ReadData(rd_a), .mem_addr(addr_a), .mem_rd_en(en_a),
    .red(r_a), .green(g_a), .blue(b_a), .de_o(de_a), .hsync_o(hs_a), .vsync_o(vs_a)
  );

  image_window_renderer #(
    .IMG_W(200), .IMG_H(200), .SCALE_LOG2(1), .FORMAT(1), .MEM_LATENCY(3),
    .ADDR_W(16), .ORG_X_DEF(10'd0), .ORG_Y_DEF(10'd0), .BG_COLOR(BG)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de_i(de_i), .hsync_i(hsync_i),
    .vsync_i(vsync_i), .org_x_in(org_x_in), .org_y_in(org_y_in),
    .org_load(org_load), .ReadData(rd_b), .mem_addr(addr_b), .mem_rd_en(en_b),
    .red(r_b), .green(g_b), .blue(b_b), .de_o(de_b), .hsync_o(hs_b), .vsync_o(vs_b)
  );

  // Instance configuration as seen by the model
  function automatic int p_scale(input int d); return (d == 0) ? 0 : 1; endfunction
  function automatic int p_fmt(input int d);   return (d == 0) ? 0 : 1; endfunction
  function automatic int p_lat(input int d);   return (d == 0) ? 1 : 3; endfunction

  // Frame-memory contents: a fixed scrambling of the address
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] w;
    w = {16'h0000, a} * 32'h9E3779B1;
    return w ^ (w >> 13);
  endfunction

  // RGB332 expansion by bit replication
  function automatic logic [23:0] rgb332(input logic [7:0] b);
    return {b[7:5], b[7:5], b[7:6], b[4:2], b[4:2], b[4:3], b[1:0], b[1:0], b[1:0], b[1:0]};
  endfunction

  // Window membership and source index in plain integer arithmetic
  task automatic model_pix(input int d, input int xv, input int yv, input int de,
                           input int ox, input int oy, output bit win,
                           output int idx, output int word, output int bsel);
    int s;
    s   = p_scale(d);
    win = (de != 0) && (xv >= ox) && (xv < ox + (200 << s))
          && (yv >= oy) && (yv < oy + (200 << s));
    idx = win ? (((yv - oy) >> s) * 200 + ((xv - ox) >> s)) : 0;
    word = (p_fmt(d) == 1) ? idx / 4 : idx;
    bsel = idx % 4;
  endtask

  // Model memory: word issued on mem_addr appears p_lat cycles later
  logic [31:0] mp_a0, mp_b0, mp_b1, mp_b2;
  always @(posedge clk) begin
    mp_a0 <= mem_word(addr_a);
    mp_b0 <= mem_word(addr_b);
    mp_b1 <= mp_b0;
    mp_b2 <= mp_b1;
  end
  assign rd_a = mp_a0;
  assign rd_b = mp_b2;

  // Behavioural model state
  int          sh_x, sh_y, ac_x, ac_y;
  int          cnt;
  logic [26:0] hist [2][HN];
  logic [15:0] ex_addr [2];
  logic        ex_rd [2];

  task automatic model_reset();
    sh_x = 0; sh_y = 0; ac_x = 0; ac_y = 0;
    for (int d = 0; d < 2; d++) begin
      ex_addr[d] = 16'h0000;
      ex_rd[d]   = 1'b0;
      for (int i = 0; i < HN; i++) hist[d][i] = '0;
    end
  endtask

  task automatic model_step();
    bit          win;
    int          idx, word, bsel;
    logic [31:0] w;
    logic [23:0] rgb;
    for (int d = 0; d < 2; d++) begin
      model_pix(d, int'(x), int'(y), int'(de_i), ac_x, ac_y, win, idx, word, bsel);
      if (!de_i) rgb = 24'h000000;
      else if (!win) rgb = BG;
      else begin
        w = mem_word(16'(word));
        rgb = (p_fmt(d) == 1) ? rgb332(w[8*bsel +: 8]) : w[23:0];
      end
      hist[d][cnt % HN] = {rgb, de_i, hsync_i, vsync_i};
      ex_rd[d] = win;
      if (win) ex_addr[d] = 16'(word);
    end
    cnt++;
    if (vsync_i) begin ac_x = sh_x; ac_y = sh_y; end
    if (org_load) begin sh_x = int'(org_x_in); sh_y = int'(org_y_in); end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison of both instances against the model
  task automatic check_dut(input int d, input logic [26:0] got, input logic [15:0] ga,
                           input logic ge);
    logic [26:0] e;
    e = hist[d][((cnt - p_lat(d) - 2) % HN + HN) % HN];
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL out[%0d] cyc %0d got rgb/de/hs/vs %h exp %h", d, cnt, got, e);
    end
    checks++;
    if ({ge, ga} !== {ex_rd[d], ex_addr[d]}) begin
      errors++;
      $display("FAIL mem[%0d] cyc %0d got en/addr %b/%h exp %b/%h", d, cnt, ge, ga,
               ex_rd[d], ex_addr[d]);
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, {r_a, g_a, b_a, de_a, hs_a, vs_a}, addr_a, en_a);
    check_dut(1, {r_b, g_b, b_b, de_b, hs_b, vs_b}, addr_b, en_b);
  end

  task automatic pin(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL pin %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input int xv, input int yv, input bit de, input bit hs,
                       input bit vs, input bit ld, input int ox, input int oy);
    x = 10'(xv); y = 10'(yv); de_i = de; hsync_i = hs; vsync_i = vs;
    org_load = ld; org_x_in = 10'(ox); org_y_in = 10'(oy);
    @(posedge clk);
    #1;
  endtask

  task automatic row(input int yv, input int x0, input int x1, input bit de);
    for (int i = x0; i <= x1; i++) drive(i, yv, de, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic vblank(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    bit win;
    int idx, word, bsel;
    int exp_bs [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    checks = 0; errors = 0; cnt = 0;
    rst_n = 1'b0;
    x = '0; y = '0; de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    org_load = 1'b0; org_x_in = '0; org_y_in = '0;
    model_reset();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state, literal
    pin("reset_rgb_a", int'({r_a, g_a, b_a}), 0);
    pin("reset_rgb_b", int'({r_b, g_b, b_b}), 0);
    pin("reset_mem_a", int'({en_a, addr_a}), 0);
    pin("reset_sync", int'({de_a, hs_a, vs_a, de_b, hs_b, vs_b}), 0);

    // Model pins: hand-derived window, index and colour expectations
    model_pix(0, 200, 0, 1, 0, 0, win, idx, word, bsel);
    pin("x200_outside", int'(win), 0);
    model_pix(0, 5, 0, 1, 0, 0, win, idx, word, bsel);
    pin("x5_word", word, 5);
    for (int i = 0; i < 8; i++) begin
      model_pix(1, i, 0, 1, 0, 0, win, idx, word, bsel);
      pin("fmt1_word", word, 0);
      pin("fmt1_bsel", bsel, exp_bs[i]);
    end
    model_pix(0, 1023, 0, 1, 900, 0, win, idx, word, bsel);
    pin("clip_1023_win", int'(win), 1);
    pin("clip_1023_idx", idx, 123);
    model_pix(0, 899, 0, 1, 900, 0, win, idx, word, bsel);
    pin("clip_899_out", int'(win), 0);
    pin("rgb332_E0", int'(rgb332(8'hE0)), 24'hFF0000);
    pin("rgb332_1C", int'(rgb332(8'h1C)), 24'h00FF00);
    pin("rgb332_03", int'(rgb332(8'h03)), 24'h0000FF);

    // First line through and past the window edge
    row(0, 0, 210, 1'b1);
    row(1, 0, 20, 1'b1);

    // Origin move armed mid-frame, applied only at vsync
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 100, 50);
    row(50, 95, 110, 1'b1);
    vblank(3);
    row(50, 95, 110, 1'b1);
    row(51, 98, 104, 1'b1);

    // Load coinciding with vsync, then clipping at the right screen edge
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 900, 0);
    row(0, 880, 890, 1'b1);
    vblank(2);
    row(0, 880, 1023, 1'b1);
    row(1, 890, 1023, 1'b1);

    // Display enable low inside the window
    row(2, 900, 950, 1'b0);

    // Single-cycle reset mid-line; origin returns to its default
    row(3, 900, 910, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    pin("midrst_rgb_a", int'({r_a, g_a, b_a, de_a}), 0);
    pin("midrst_rgb_b", int'({r_b, g_b, b_b, de_b}), 0);
    pin("midrst_mem", int'({en_a, addr_a, en_b, addr_b}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    row(3, 0, 12, 1'b1);
    row(3, 900, 905, 1'b1);

    // Randomised scan with occasional origin loads and vsync
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 450)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 450)),
            $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0,
            int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    end

    repeat (8) drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_window_renderer.md
# image_window_renderer

Pipelined, parametrised image-window pixel generator for the VGA path of the processor. It maps the scan position (x, y) to a frame-memory word address and issues the read. It then realigns the returned word with delayed sync/blank so that window pixels and background colour arrive on the correct pixel. Compared with the fixed 200x200 rectangle generator, it adds runtime-movable origin, integer pixel scaling, two pixel formats, and memory-latency compensation.

## Interface
- IMG_W, 200, image width in source pixels
- IMG_H, 200, image height in source pixels
- SCALE_LOG2, 0, each source pixel drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels (0..3)
- FORMAT, 0, 0 = one RGB888 pixel per 32-bit word in bits [23:0]; 1 = four RGB332 pixels per word, pixel n in byte n
- MEM_LATENCY, 1, cycles from mem_addr to valid ReadData (1..4)
- ADDR_W, 16, width of mem_addr
- ORG_X_DEF, 0, origin x after reset
- ORG_Y_DEF, 0, origin y after reset
- BG_COLOR, 24'h555555, RGB shown in active video outside the window
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- x, y  in  10 each  current scan position
- de_i, hsync_i, vsync_i  in  1 each  display enable and syncs from the VGA controller; vsync_i is active high
- org_x_in, org_y_in  in  10 each  new window origin
- org_load  in  1  captures org_x_in/org_y_in into the shadow registers
- ReadData  in  32  frame-memory data, valid MEM_LATENCY cycles after mem_addr
- mem_addr  out  ADDR_W  word address
- mem_rd_en  out  1  high when mem_addr targets a window pixel
- red, green, blue  out  8 each  pixel colour
- de_o, hsync_o, vsync_o  out  1 each  de_i/hsync_i/vsync_i delayed to match the colour outputs

## Operation
- Origin handling:
  - Shadow registers load on org_load.
  - Active origin copies the shadow on every cycle with vsync_i high, so the window never moves mid-frame.
  - If org_load and vsync_i are high in the same cycle, the new value reaches the active origin one cycle later.
- Window test, evaluated in 11-bit arithmetic with no wrap:
  - in_win = de_i && x >= org_x && x < org_x + (IMG_W<<SCALE_LOG2) && y >= org_y && y < org_y + (IMG_H<<SCALE_LOG2).
  - A window extending past 1023 is clipped.
- Address generation:
  - rx = (x - org_x) >> SCALE_LOG2; ry = (y - org_y) >> SCALE_LOG2; idx = ry*IMG_W + rx.
  - FORMAT 0: word = idx. FORMAT 1: word = idx>>2, byte_sel = idx[1:0].
  - mem_addr = word truncated to ADDR_W bits.
- Outside the window, mem_addr holds its last value and mem_rd_en = 0.
- Pipeline carries in_win, de, hsync, vsync and byte_sel alongside the read.
- Colour at the output stage:
  - de = 0: RGB = 0.
  - de = 1, not in_win: BG_COLOR.
  - in_win, FORMAT 0: ReadData[23:16], [15:8], [7:0].
  - in_win, FORMAT 1: byte b = ReadData[8*byte_sel +: 8]. red = {b[7:5], b[7:5], b[7:6]}; green = {b[4:2], b[4:2], b[4:3]}; blue = {b[1:0], b[1:0], b[1:0], b[1:0]}.

## Timing
- Stage 0 (registered): mem_addr, mem_rd_en, tagged in_win/de/syncs/byte_sel. Visible 1 cycle after x, y.
- Stages 1..MEM_LATENCY: tag delay line.
- Output stage (registered): colour mux.
- Total latency from x, y, de_i, syncs to red/green/blue, de_o, sync outputs: MEM_LATENCY+2 cycles, constant, no bubbles.
- No stall or handshake. One new pixel is accepted per cycle and memory must sustain one read per cycle.
- Reset (asynchronous assert, synchronous release behaviour):
  - mem_addr = 0, mem_rd_en = 0.
  - red/green/blue = 0, de_o/hsync_o/vsync_o = 0.
  - All pipeline tags cleared.
  - Active and shadow origin = ORG_X_DEF/ORG_Y_DEF.
- Reset mid-frame: outputs are 0 until the pipeline refills, which takes MEM_LATENCY+2 cycles after release.

## Test plan
- Defaults, MEM_LATENCY=1. Drive x=0..199 with y=0, de_i=1, and memory returning word k = 24'h0000k0 | k. Required: each pixel's RGB equals its word, 3 cycles later. At x=200 the output is 55/55/55 and mem_rd_en = 0.
- FORMAT=1, SCALE_LOG2=1. Drive x=0..7 at y=0 with ReadData=32'hFF_E0_1C_03. Required: mem_addr = 0 for all eight pixels; byte_sel sequence 0,0,1,1,2,2,3,3; RGB for byte 8'hE0 = FF/00/00.
- Move origin: org_load with (100,50) while vsync_i=0. Required: the window stays at (0,0) until vsync_i rises. On the next frame, (x,y)=(100,50) gives mem_addr 0 and (99,50) gives background.
- Clipping: origin (900,0), IMG_W=200. Required: in_win is true for x=900..1023 and no wrap to x<900; x=1023 gives idx 123.
- de_i low inside the window. Required: RGB = 0 and de_o = 0 after latency.
- Assert rst_n low for 1 cycle mid-line. Required: all outputs read 0 immediately, and the origin returns to its defaults.
